// File: rtl/mwpram_wsched.sv
// ---------------------------------------------------------------------------
// mwpram_wsched
//
// Write scheduler for a multi-write-port RAM. It shares the RAM's `wports`
// write ports among `nreq` requesters using a valid/ready handshake with
// rotating priority. It never issues two writes to the same address in one
// cycle. After every reset it sweeps the whole RAM with zeros, because the
// RAM itself has no reset.
//
// Parameters:
//   width   data width of one RAM entry
//   depth   number of RAM entries (aw = $clog2(depth) address bits)
//   wports  number of RAM write ports driven
//   nreq    number of requesters, nreq >= wports
//
// Ports:
//   clk        clock, single domain
//   rst        synchronous active-high reset
//   req_valid  requester i has a write pending
//   req_addr   write address of requester i
//   req_value  write data of requester i
//   req_ready  requester i is granted this cycle (combinational)
//   waddr      RAM write address per port (registered)
//   wvalue     RAM write data per port (registered)
//   wena       RAM write enable per port (registered)
//   init_busy  high while the zeroing sweep runs (registered)
// ---------------------------------------------------------------------------
module mwpram_wsched #(
    parameter  int width  = 64,
    parameter  int depth  = 64,
    parameter  int wports = 2,
    parameter  int nreq   = 4,
    localparam int aw     = $clog2(depth),
    localparam int pw     = (nreq > 1) ? $clog2(nreq) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [nreq-1:0]              req_valid,
    input  logic [nreq-1:0][aw-1:0]      req_addr,
    input  logic [nreq-1:0][width-1:0]   req_value,
    output logic [nreq-1:0]              req_ready,
    output logic [wports-1:0][aw-1:0]    waddr,
    output logic [wports-1:0][width-1:0] wvalue,
    output logic [wports-1:0]            wena,
    output logic                         init_busy
);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t                         state, state_nxt;
    logic [aw-1:0]                  cnt, cnt_nxt;
    logic [pw-1:0]                  ptr, ptr_nxt;
    logic [wports-1:0]              wena_nxt;
    logic [wports-1:0][aw-1:0]      waddr_nxt;
    logic [wports-1:0][width-1:0]   wvalue_nxt;

    // Next-state, arbitration and next output-register contents.
    always_comb begin : sched
        int   gcnt;
        int   idx;
        logic clash;

        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned; otherwise synthesis would infer latches.
        state_nxt  = state;
        cnt_nxt    = cnt;
        ptr_nxt    = ptr;
        req_ready  = '0;
        wena_nxt   = '0;
        waddr_nxt  = '0;
        wvalue_nxt = '0;
        gcnt       = 0;
        idx        = 0;
        clash      = 1'b0;

        case (state)
            INIT: begin
                // One zero write per cycle on port 0, addresses in order.
                wena_nxt[0]  = 1'b1;
                waddr_nxt[0] = cnt;
                cnt_nxt      = cnt + 1'b1;
                if (cnt == aw'(depth - 1)) begin
                    state_nxt = RUN;
                end
            end

            RUN: begin
                if (!rst) begin
                    // Scan from ptr with wrap-around; the k-th grant lands on
                    // port k, so waddr_nxt[0..gcnt-1] are the addresses
                    // already claimed this cycle.
                    for (int s = 0; s < nreq; s++) begin
                        idx = int'(ptr) + s;
                        if (idx >= nreq) begin
                            idx = idx - nreq;
                        end
                        clash = 1'b0;
                        for (int k = 0; k < wports; k++) begin
                            if (k < gcnt && waddr_nxt[k] == req_addr[idx]) begin
                                clash = 1'b1;
                            end
                        end
                        if (req_valid[idx] && gcnt < wports && !clash) begin
                            req_ready[idx] = 1'b1;
                            for (int k = 0; k < wports; k++) begin
                                if (k == gcnt) begin
                                    wena_nxt[k]   = 1'b1;
                                    waddr_nxt[k]  = req_addr[idx];
                                    wvalue_nxt[k] = req_value[idx];
                                end
                            end
                            // Restart the next scan just past the last winner.
                            ptr_nxt = (idx == nreq - 1) ? '0 : pw'(idx + 1);
                            gcnt    = gcnt + 1;
                        end
                    end
                end
            end

            default: ;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state     <= INIT;
            cnt       <= '0;
            ptr       <= '0;
            wena      <= '0;
            waddr     <= '0;
            wvalue    <= '0;
            init_busy <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ptr       <= ptr_nxt;
            wena      <= wena_nxt;
            waddr     <= waddr_nxt;
            wvalue    <= wvalue_nxt;
            init_busy <= (state_nxt == INIT);
        end
    end

endmodule

// File: tb/tb_mwpram_wsched.sv
// ---------------------------------------------------------------------------
// tb_mwpram_wsched
//
// Self-checking bench for mwpram_wsched (depth=16, nreq=4, wports=2).
// A behavioural RAM absorbs the scheduler's write ports; a reference memory
// is updated from observed handshakes. Directed table vectors cover the
// arbitration cases, hand-written sequences cover the zeroing sweep and
// resets, and a random phase cross-checks the final RAM contents.
// ---------------------------------------------------------------------------
module tb_mwpram_wsched;

    localparam int W     = 64;
    localparam int DEPTH = 16;
    localparam int NR    = 4;
    localparam int WP    = 2;
    localparam int AW    = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NR-1:0]         req_valid;
    logic [NR-1:0][AW-1:0] req_addr;
    logic [NR-1:0][W-1:0]  req_value;
    logic [NR-1:0]         req_ready;
    logic [WP-1:0][AW-1:0] waddr;
    logic [WP-1:0][W-1:0]  wvalue;
    logic [WP-1:0]         wena;
    logic                  init_busy;

    logic [W-1:0] ram     [DEPTH];
    logic [W-1:0] exp_mem [DEPTH];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NR-1:0]         valid;
        logic [NR-1:0][AW-1:0] addr;
        logic [NR-1:0][W-1:0]  value;
        logic [NR-1:0]         ready;
        logic [WP-1:0]         wena;
        logic [WP-1:0][AW-1:0] waddr;
        logic [WP-1:0][W-1:0]  wvalue;
    } vec_t;

    vec_t vecs [12];

    mwpram_wsched #(
        .width (W),
        .depth (DEPTH),
        .wports(WP),
        .nreq  (NR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_addr (req_addr),
        .req_value(req_value),
        .req_ready(req_ready),
        .waddr    (waddr),
        .wvalue   (wvalue),
        .wena     (wena),
        .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    // Behavioural RAM with no reset, written from the scheduler's ports.
    always @(posedge clk) begin
        for (int k = 0; k < WP; k++) begin
            if (wena[k]) ram[waddr[k]] <= wvalue[k];
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Both ports writing the same address in one cycle is never allowed.
    always @(negedge clk) begin
        if (!rst && wena == 2'b11) check("dup_addr", 128'(waddr[0] != waddr[1]), 128'd1);
    end

    // Record accepted handshakes into the reference memory (called #1 after
    // inputs settle, before the capturing edge).
    task automatic log_hs();
        for (int i = 0; i < NR; i++) begin
            if (!rst && req_valid[i] && req_ready[i]) exp_mem[req_addr[i]] = req_value[i];
        end
    endtask

    // Apply one table vector at a negedge, check ready, then the registered
    // outputs #1 after the next posedge; returns at the following negedge.
    task automatic step(input vec_t v, input int n);
        req_valid = v.valid;
        req_addr  = v.addr;
        req_value = v.value;
        #1;
        log_hs();
        check($sformatf("v%0d_ready", n), 128'(req_ready), 128'(v.ready));
        @(posedge clk);
        #1;
        check($sformatf("v%0d_wena", n), 128'(wena), 128'(v.wena));
        for (int k = 0; k < WP; k++) begin
            if (v.wena[k]) begin
                check($sformatf("v%0d_waddr%0d", n, k), 128'(waddr[k]), 128'(v.waddr[k]));
                check($sformatf("v%0d_wvalue%0d", n, k), 128'(wvalue[k]), 128'(v.wvalue[k]));
            end
        end
        @(negedge clk);
    endtask

    // Reset pulse started at a negedge with all requesters valid.
    task automatic reset_pulse();
        rst       = 1'b1;
        req_valid = '1;
        req_addr  = {4'd4, 4'd3, 4'd2, 4'd1};
        req_value = {64'h44, 64'h33, 64'h22, 64'h11};
        for (int a = 0; a < DEPTH; a++) exp_mem[a] = '0;
        #1;
        check("rst_ready", 128'(req_ready), 128'd0);
        @(posedge clk);
        #1;
        check("rst_wena", 128'(wena), 128'd0);
        check("rst_waddr", 128'(waddr), 128'd0);
        check("rst_busy", 128'(init_busy), 128'd1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Observe n cycles of the zeroing sweep (requesters stay valid).
    task automatic sweep(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("sweep_wena", 128'(wena), 128'b01);
            check("sweep_addr", 128'(waddr[0]), 128'(i));
            check("sweep_value", 128'(wvalue[0]), 128'd0);
            check("sweep_busy", 128'(init_busy), 128'(i < DEPTH - 1));
            if (i < DEPTH - 1) check("sweep_ready", 128'(req_ready), 128'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NR-1:0] hs;
        int            wait_c [NR];
        int            max_wait;
        int            bad;
        int            viol;

        // Directed vectors; ptr starts at 0 after the sweep.
        vecs[0]  = '{valid: 4'b0000, addr: '0, value: '0,
                     ready: 4'b0000, wena: 2'b00, waddr: '0, wvalue: '0};
        vecs[1]  = '{valid: 4'b1111, addr: {4'd4, 4'd3, 4'd2, 4'd1},
                     value: {64'h44, 64'h33, 64'h22, 64'h11},
                     ready: 4'b0011, wena: 2'b11, waddr: {4'd2, 4'd1}, wvalue: {64'h22, 64'h11}};
        vecs[2]  = '{valid: 4'b1111, addr: {4'd4, 4'd3, 4'd2, 4'd1},
                     value: {64'h44, 64'h33, 64'h22, 64'h11},
                     ready: 4'b1100, wena: 2'b11, waddr: {4'd4, 4'd3}, wvalue: {64'h44, 64'h33}};
        vecs[3]  = '{valid: 4'b1111, addr: {4'd4, 4'd3, 4'd2, 4'd1},
                     value: {64'h44, 64'h33, 64'h22, 64'h11},
                     ready: 4'b0011, wena: 2'b11, waddr: {4'd2, 4'd1}, wvalue: {64'h22, 64'h11}};
        vecs[4]  = '{valid: 4'b0100, addr: {4'd0, 4'd7, 4'd0, 4'd0},
                     value: {64'h0, 64'h77, 64'h0, 64'h0},
                     ready: 4'b0100, wena: 2'b01, waddr: {4'd0, 4'd7}, wvalue: {64'h0, 64'h77}};
        vecs[5]  = '{valid: 4'b1000, addr: {4'd9, 4'd0, 4'd0, 4'd0},
                     value: {64'hABCD, 64'h0, 64'h0, 64'h0},
                     ready: 4'b1000, wena: 2'b01, waddr: {4'd0, 4'd9}, wvalue: {64'h0, 64'hABCD}};
        vecs[6]  = '{valid: 4'b0111, addr: {4'd0, 4'd6, 4'd5, 4'd5},
                     value: {64'h0, 64'hB2, 64'hA1, 64'hA0},
                     ready: 4'b0101, wena: 2'b11, waddr: {4'd6, 4'd5}, wvalue: {64'hB2, 64'hA0}};
        vecs[7]  = '{valid: 4'b0010, addr: {4'd0, 4'd0, 4'd5, 4'd0},
                     value: {64'h0, 64'h0, 64'hA1, 64'h0},
                     ready: 4'b0010, wena: 2'b01, waddr: {4'd0, 4'd5}, wvalue: {64'h0, 64'hA1}};
        vecs[8]  = '{valid: 4'b1111, addr: {4'd8, 4'd8, 4'd8, 4'd8},
                     value: {64'hC3, 64'hC2, 64'hC1, 64'hC0},
                     ready: 4'b0100, wena: 2'b01, waddr: {4'd0, 4'd8}, wvalue: {64'h0, 64'hC2}};
        vecs[9]  = '{valid: 4'b1001, addr: {4'd11, 4'd0, 4'd0, 4'd10},
                     value: {64'hD3, 64'h0, 64'h0, 64'hD0},
                     ready: 4'b1001, wena: 2'b11, waddr: {4'd10, 4'd11}, wvalue: {64'hD0, 64'hD3}};
        vecs[10] = '{valid: 4'b1110, addr: {4'd14, 4'd13, 4'd12, 4'd0},
                     value: {64'hE3, 64'hE2, 64'hE1, 64'h0},
                     ready: 4'b0110, wena: 2'b11, waddr: {4'd13, 4'd12}, wvalue: {64'hE2, 64'hE1}};
        vecs[11] = '{valid: 4'b1110, addr: {4'd14, 4'd13, 4'd12, 4'd0},
                     value: {64'hE3, 64'hE2, 64'hE1, 64'h0},
                     ready: 4'b1010, wena: 2'b11, waddr: {4'd12, 4'd14}, wvalue: {64'hE1, 64'hE3}};

        // Power-up reset and first full sweep.
        req_valid = '1;
        req_addr  = {4'd4, 4'd3, 4'd2, 4'd1};
        req_value = {64'h44, 64'h33, 64'h22, 64'h11};
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_pulse();
        sweep(DEPTH);
        check("ptr0_after_sweep", 128'(req_ready), 128'b0011);
        @(negedge clk);
        req_valid = '0;
        @(posedge clk);
        #1;
        check("idle_wena", 128'(wena), 128'd0);
        @(negedge clk);
        bad = 0;
        for (int a = 0; a < DEPTH; a++) if (ram[a] !== '0) bad++;
        check("ram_zeroed", 128'(bad), 128'd0);

        // Table-driven arbitration vectors.
        for (int n = 0; n < 12; n++) step(vecs[n], n);
        req_valid = '0;
        repeat (2) @(negedge clk);
        check("ram5_last_writer", 128'(ram[5]), 128'hA1);

        // Reset with a write in flight (ptr=2 here, so req0 wins), then a
        // reset mid-sweep at cnt=5, then a complete sweep from address 0.
        step('{valid: 4'b0001, addr: {4'd0, 4'd0, 4'd0, 4'd3},
               value: {64'h0, 64'h0, 64'h0, 64'h55},
               ready: 4'b0001, wena: 2'b01, waddr: {4'd0, 4'd3}, wvalue: {64'h0, 64'h55}}, 12);
        reset_pulse();
        sweep(5);
        @(negedge clk);
        reset_pulse();
        sweep(DEPTH);
        check("ptr0_after_resweep", 128'(req_ready), 128'b0011);
        @(negedge clk);
        req_valid = '0;

        // Random phase: requesters hold valid/addr/value until granted.
        hs       = '0;
        max_wait = 0;
        viol     = 0;
        for (int i = 0; i < NR; i++) wait_c[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] || hs[i]) begin
                    req_valid[i] = ($urandom_range(0, 1) == 1);
                    req_addr[i]  = 4'($urandom_range(0, DEPTH - 1));
                    req_value[i] = {$urandom, $urandom};
                end
            end
            #1;
            log_hs();
            hs = req_valid & req_ready;
            if ((req_ready & ~req_valid) != '0) viol++;
            for (int i = 0; i < NR; i++) begin
                wait_c[i] = (req_valid[i] && !req_ready[i]) ? wait_c[i] + 1 : 0;
                if (wait_c[i] > max_wait) max_wait = wait_c[i];
            end
            @(negedge clk);
        end
        req_valid = '0;
        repeat (3) @(negedge clk);
        check("ready_only_if_valid", 128'(viol), 128'd0);
        check("max_wait_bounded", 128'(max_wait <= 4), 128'd1);
        for (int a = 0; a < DEPTH; a++) begin
            check($sformatf("ram_final[%0d]", a), 128'(ram[a]), 128'(exp_mem[a]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
